// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between the fetch and data stages.
// One access at a time; data has priority, bounded by a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              if_stall_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o,
  output logic [1:0]        grant_o
);

  localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_e;

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [1:0]        grant_q, grant_d;

  logic              fetch_wins;
  logic              finish;
  logic [DATA_W-1:0] resp_data;

  // Fetch takes a contended slot only once data has used up its run allowance.
  assign fetch_wins = if_req_i && (!dm_req_i || run_cnt_q == RUN_W'(MAX_DATA_RUN));

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    grant_d     = grant_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    finish      = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (fetch_wins) begin
          state_d     = BUSY_IF;
          grant_d     = 2'b01;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          run_cnt_d   = '0;
          wait_d      = '0;
        end else if (dm_req_i) begin
          state_d     = BUSY_DM;
          grant_d     = 2'b10;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          // Only reachable below MAX_DATA_RUN when contended, so +1 saturates by construction.
          run_cnt_d   = if_req_i ? run_cnt_q + RUN_W'(1) : '0;
          wait_d      = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack_i) begin
          finish    = 1'b1;
          resp_data = mem_we_q ? '0 : mem_rdata_i;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d   = RESP;
      mem_req_d = 1'b0;
      if (state_q == BUSY_IF) begin
        if_ack_d   = 1'b1;
        if_rdata_d = resp_data;
      end else begin
        dm_ack_d   = 1'b1;
        dm_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      grant_q     <= grant_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;
  assign grant_o     = grant_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized requesters and memory
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXR = 4;
  localparam int TO   = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_ack_o, dm_req_i, dm_we_i, dm_ack_o;
  logic [31:0] if_addr_i, if_rdata_o, dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        if_stall_o, dm_stall_o, mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]  grant_o;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(MAXR), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .if_stall_o(if_stall_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester transaction: what the stage asked for, independent of what it drives later.
  typedef struct {
    bit          out;
    bit          granted;
    bit          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        ag [2];
  int          p_req [2];
  int          p_drop;
  int          lat_mode;
  bit          allow_new;

  bit          act, done, exp_err;
  int          owner, m_n, run_m;
  txn_t        cur;
  logic [31:0] exp_rd;
  logic [31:0] last_rd [2];
  logic [1:0]  grant_log [$];

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          env_prev_req;
  int          env_n, env_lat, env_last_len;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int pick_lat();
    int r;
    if (lat_mode == 1) return 0;
    if (lat_mode == 2) return 1000;
    r = int'($urandom_range(99));
    return (r < 12) ? 1000 : r % 4;
  endfunction

  task automatic cycle();
    logic        s_mreq, s_we, s_ack0, s_ack1, s_err;
    logic [1:0]  s_gr;
    logic [31:0] s_addr, s_wdata, s_rd0, s_rd1;
    @(negedge clk_i);
    s_mreq = mem_req_o;  s_we = mem_we_o;   s_ack0 = if_ack_o; s_ack1 = dm_ack_o;
    s_err  = err_o;      s_gr = grant_o;    s_addr = mem_addr_o; s_wdata = mem_wdata_o;
    s_rd0  = if_rdata_o; s_rd1 = dm_rdata_o;

    // Expected outputs for this cycle.
    if (act && !done) begin
      if (m_n == 0) grant_log.push_back(s_gr);
      check("mem_req_busy", s_mreq, 1);
      check("grant_busy", s_gr, (owner == 0) ? 2'b01 : 2'b10);
      check("mem_addr", s_addr, cur.addr);
      check("mem_we", s_we, cur.we);
      if (cur.we) check("mem_wdata", s_wdata, cur.wdata);
      check("acks_busy", {s_ack0, s_ack1, s_err}, 0);
    end else if (act) begin
      check("mem_req_resp", s_mreq, 0);
      check("if_ack_resp", s_ack0, owner == 0);
      check("dm_ack_resp", s_ack1, owner == 1);
      check("err_resp", s_err, exp_err);
      last_rd[owner] = exp_rd;
    end else begin
      check("idle_outs", {s_mreq, s_gr, s_ack0, s_ack1, s_err}, 0);
    end
    check("if_rdata", s_rd0, last_rd[0]);
    check("dm_rdata", s_rd1, last_rd[1]);

    // Requesting stages.
    for (int p = 0; p < 2; p++) begin
      if (ag[p].out && ((p == 0) ? s_ack0 : s_ack1)) begin
        ag[p].out = 0; ag[p].granted = 0; ag[p].req = 0;
      end
      if (!ag[p].out && allow_new && (int'($urandom_range(99)) < p_req[p])) begin
        ag[p].out     = 1;
        ag[p].req     = 1;
        ag[p].addr    = 32'h100 + 32'($urandom_range(7)) * 32'd4;
        ag[p].we      = (p == 1) ? 1'($urandom_range(1)) : 1'b0;
        ag[p].wdata   = $urandom;
      end else if (ag[p].granted && ag[p].req && (int'($urandom_range(99)) < p_drop)) begin
        ag[p].req = 0;
      end
    end
    if_req_i   = ag[0].req;
    dm_req_i   = ag[1].req;
    if_addr_i  = ag[0].granted ? $urandom : ag[0].addr;
    dm_addr_i  = ag[1].granted ? $urandom : ag[1].addr;
    dm_we_i    = ag[1].granted ? 1'($urandom) : ag[1].we;
    dm_wdata_i = ag[1].granted ? $urandom : ag[1].wdata;

    // Memory environment reacting to the DUT's memory port.
    if (s_mreq) begin
      if (!env_prev_req) begin
        env_n = 0;
        env_lat = pick_lat();
      end
      mem_ack_i = (env_n == env_lat);
      if (mem_ack_i) begin
        mem_rdata_i = s_we ? $urandom : (env_mem.exists(s_addr) ? env_mem[s_addr] : init_val(s_addr));
        if (s_we) env_mem[s_addr] = s_wdata;
      end else begin
        mem_rdata_i = $urandom;
      end
      env_n++;
    end else begin
      if (env_prev_req) env_last_len = env_n;
      mem_ack_i   = ($urandom_range(3) == 0);
      mem_rdata_i = $urandom;
    end
    env_prev_req = s_mreq;

    // Reference model: advance by one cycle using this cycle's inputs.
    if (act && done) begin
      act = 0;
    end else if (act) begin
      if (mem_ack_i) begin
        done = 1; exp_err = 0;
        if (cur.we) begin
          exp_rd = '0;
          ref_mem[cur.addr] = cur.wdata;
        end else begin
          exp_rd = ref_rd(cur.addr);
        end
      end else if (m_n == TO - 1) begin
        done = 1; exp_err = 1; exp_rd = '0;
      end
      m_n++;
    end else begin
      int pick = -1;
      if (dm_req_i && !(if_req_i && run_m == MAXR)) begin
        pick  = 1;
        run_m = if_req_i ? run_m + 1 : 0;
      end else if (if_req_i) begin
        pick  = 0;
        run_m = 0;
      end
      if (pick >= 0) begin
        act = 1; done = 0; m_n = 0; owner = pick;
        cur = ag[pick];
        ag[pick].granted = 1;
      end
    end

    #1;
    check("if_stall", if_stall_o, if_req_i & ~s_ack0);
    check("dm_stall", dm_stall_o, dm_req_i & ~s_ack1);
  endtask

  task automatic drain();
    int guard = 0;
    allow_new = 0;
    while ((act || ag[0].out || ag[1].out) && guard < 200) begin
      cycle();
      guard++;
    end
    check("drain_done", guard < 200, 1);
    allow_new = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0; dm_addr_i = 0;
    dm_wdata_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    repeat (3) @(negedge clk_i);
    check("reset_ctrl", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, err_o, grant_o}, 0);
    check("reset_mem", {mem_addr_o, mem_wdata_o}, 0);
    check("reset_rdata", {if_rdata_o, dm_rdata_o}, 0);

    // Fetch, memory acks two cycles after mem_req_o rises.
    rst_i = 0; if_req_i = 1; if_addr_i = 32'h10;
    #1 check("fetch_stall_raise", if_stall_o, 1);
    @(negedge clk_i);
    check("fetch_req", mem_req_o, 1); check("fetch_grant", grant_o, 2'b01);
    check("fetch_addr", mem_addr_o, 32'h10); check("fetch_we", mem_we_o, 0);
    @(negedge clk_i);
    check("fetch_wait_req", mem_req_o, 1); check("fetch_wait_ack", if_ack_o, 0);
    @(negedge clk_i);
    mem_ack_i = 1; mem_rdata_i = 32'h0010_0093;
    check("fetch_no_early_ack", if_ack_o, 0);
    #1 check("fetch_stall_held", if_stall_o, 1);
    @(negedge clk_i);
    mem_ack_i = 0; mem_rdata_i = 32'hABAB_ABAB;
    check("fetch_ack", if_ack_o, 1); check("fetch_rdata", if_rdata_o, 32'h0010_0093);
    check("fetch_req_clear", mem_req_o, 0);
    #1 check("fetch_stall_release", if_stall_o, 0);
    if_req_i = 0;
    @(negedge clk_i);
    check("fetch_ack_one_cycle", if_ack_o, 0); check("fetch_rdata_hold", if_rdata_o, 32'h0010_0093);

    // Simultaneous requests, zero-wait memory: data first, fetch right after.
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100; if_req_i = 1; if_addr_i = 32'h20;
    @(negedge clk_i);
    check("both_grant_dm", grant_o, 2'b10); check("both_dm_addr", mem_addr_o, 32'h100);
    mem_ack_i = 1; mem_rdata_i = 32'h55;
    @(negedge clk_i);
    check("both_dm_ack", dm_ack_o, 1); check("both_dm_rdata", dm_rdata_o, 32'h55);
    check("both_if_wait", if_ack_o, 0);
    mem_ack_i = 0; dm_req_i = 0;
    @(negedge clk_i);
    check("both_idle_gap", mem_req_o, 0);
    @(negedge clk_i);
    check("both_grant_if", grant_o, 2'b01); check("both_if_addr", mem_addr_o, 32'h20);
    mem_ack_i = 1; mem_rdata_i = 32'h66;
    @(negedge clk_i);
    check("both_if_ack", if_ack_o, 1); check("both_if_rdata", if_rdata_o, 32'h66);
    if_req_i = 0; mem_ack_i = 0;
    @(negedge clk_i);

    // Store.
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("store_we", mem_we_o, 1); check("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("store_addr", mem_addr_o, 32'h200); check("store_grant", grant_o, 2'b10);
    mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("store_ack", dm_ack_o, 1); check("store_rdata", dm_rdata_o, 0); check("store_err", err_o, 0);
    dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
    @(negedge clk_i);

    // Reset during a fetch with a simultaneous memory ack.
    if_req_i = 1; if_addr_i = 32'h40;
    @(negedge clk_i);
    check("rst_busy_req", mem_req_o, 1);
    mem_ack_i = 1; mem_rdata_i = 32'h99; rst_i = 1;
    @(negedge clk_i);
    check("rst_no_ack", if_ack_o, 0);
    check("rst_ctrl_zero", {mem_req_o, mem_we_o, dm_ack_o, err_o, grant_o}, 0);
    check("rst_data_zero", {if_rdata_o, dm_rdata_o}, 0);
    check("rst_addr_zero", mem_addr_o, 0);
    rst_i = 0; mem_ack_i = 0;
    @(negedge clk_i);
    check("rst_refetch_req", mem_req_o, 1); check("rst_refetch_grant", grant_o, 2'b01);
    check("rst_refetch_addr", mem_addr_o, 32'h40);
    mem_ack_i = 1; mem_rdata_i = 32'h77;
    @(negedge clk_i);
    check("rst_refetch_ack", if_ack_o, 1); check("rst_refetch_rdata", if_rdata_o, 32'h77);
    if_req_i = 0; mem_ack_i = 0;

    // Model-driven phases.
    act = 0; done = 0; run_m = 0; last_rd[0] = 32'h77; last_rd[1] = 32'h0;
    env_prev_req = 0; env_last_len = 0; p_drop = 0;
    for (int p = 0; p < 2; p++) ag[p] = '{0, 0, 0, 1'b0, 32'h0, 32'h0};

    // Starvation guard: both held, zero-wait memory.
    p_req[0] = 100; p_req[1] = 100; lat_mode = 1; allow_new = 1;
    grant_log.delete();
    repeat (60) cycle();
    drain();
    check("starve_count", grant_log.size() >= 15, 1);
    for (int i = 0; i < 15 && i < grant_log.size(); i++)
      check($sformatf("starve_order%0d", i), grant_log[i], (i % 5 == 4) ? 2'b01 : 2'b10);

    // Timeout: memory never acks.
    p_req[0] = 0; p_req[1] = 100; lat_mode = 2;
    repeat (30) cycle();
    drain();
    check("timeout_req_len", env_last_len, TO);

    // Random mix.
    p_req[0] = 45; p_req[1] = 45; lat_mode = 0; p_drop = 15;
    repeat (3000) cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
